// File: rtl/alu_seq_pkg.sv
// Shared op-code encoding and FSM state type for the miniMIPS multi-cycle ALU.
package alu_seq_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_MULT = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_OR   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle datapath: add/sub/slt and bitwise ops with MSB carry and signed overflow.
module alu_comb_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);

    logic             sub_en;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_low;
    logic             add_ovf;
    logic             less;

    // slt reuses the subtractor; the carry into the MSB comes from a separate low-bits sum
    assign sub_en   = (op == ALU_SUB) || (op == ALU_SLT);
    assign b_eff    = sub_en ? ~b : b;
    assign sum_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_en};
    assign sum_low  = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, sub_en};
    assign add_ovf  = sum_low[WIDTH-1] ^ sum_full[WIDTH];
    assign less     = sum_full[WIDTH-1] ^ add_ovf;

    always_comb begin
        res  = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                res  = sum_full[WIDTH-1:0];
                cout = sum_full[WIDTH];
                ovf  = add_ovf;
            end
            ALU_SLT: res = {{(WIDTH-1){1'b0}}, less};
            ALU_XOR: res = a ^ b;
            ALU_NOR: res = ~(a | b);
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops through alu_comb_core, unsigned shift-add mult over WIDTH cycles.
//   state | meaning
//   IDLE  | ready=1; non-mult ops complete here one cycle after acceptance
//   MUL   | ready=0; one shift-add iteration per edge, WIDTH edges total
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] plo_q, plo_d;
    logic [WIDTH-1:0] phi_q, phi_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0]   core_res;
    logic               core_cout;
    logic               core_ovf;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_next;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op   (alu_op),
        .a    (a),
        .b    (b),
        .res  (core_res),
        .cout (core_cout),
        .ovf  (core_ovf)
    );

    // Product register {phi, plo} starts as {0, b}; each step adds a when plo[0] and shifts right
    assign step_sum  = {1'b0, phi_q} + (plo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign prod_next = {step_sum, plo_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        plo_d   = plo_q;
        phi_d   = phi_q;
        res_d   = res_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (alu_op == ALU_MULT) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        mcand_d = a;
                        plo_d   = b;
                        phi_d   = '0;
                    end else begin
                        res_d  = core_res;
                        hi_d   = '0;
                        zero_d = (core_res == '0);
                        cout_d = core_cout;
                        ovf_d  = core_ovf;
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                phi_d = prod_next[2*WIDTH-1:WIDTH];
                plo_d = prod_next[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    res_d   = prod_next[WIDTH-1:0];
                    hi_d    = prod_next[2*WIDTH-1:WIDTH];
                    zero_d  = (prod_next[WIDTH-1:0] == '0);
                    cout_d  = 1'b0;
                    ovf_d   = |prod_next[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            plo_q   <= '0;
            phi_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            plo_q   <= plo_d;
            phi_q   <= phi_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign result    = res_q;
    assign result_hi = hi_q;
    assign zero      = zero_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed + scoreboard bench for alu_seq at WIDTH=8.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   alu_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         carry_out;
    logic         overflow;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [W-1:0] r, input logic [W-1:0] h,
                                input logic c, input logic v);
        exp_t e;
        e.tag = tag; e.res = r; e.hi = h; e.z = (r == '0); e.c = c; e.v = v;
        return e;
    endfunction

    // Reference model for randomised vectors, written in plain arithmetic terms
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0]   s;
        logic [2*W-1:0] p;
        exp_t e;
        case (op)
            ALU_ADD: begin
                s = x + y;
                e = mk("rand_add", s, '0, ({1'b0, x} + {1'b0, y}) > 9'd255,
                       (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]));
            end
            ALU_SUB: begin
                s = x - y;
                e = mk("rand_sub", s, '0, x >= y, (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]));
            end
            default: begin
                p = {8'h00, x} * {8'h00, y};
                e = mk("rand_mult", p[W-1:0], p[2*W-1:W], 1'b0, p[2*W-1:W] != '0);
            end
        endcase
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_done: observed=1 expected=0 result=%0h", result);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_result"}, {8'h00, result}, {8'h00, e.res});
                check({e.tag, "_hi"}, {8'h00, result_hi}, {8'h00, e.hi});
                check({e.tag, "_zero"}, {15'd0, zero}, {15'd0, e.z});
                check({e.tag, "_carry"}, {15'd0, carry_out}, {15'd0, e.c});
                check({e.tag, "_ovf"}, {15'd0, overflow}, {15'd0, e.v});
            end
        end
    end

    // Drive one request at a negedge; returns at the negedge after the acceptance edge
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        start  = 1'b1;
        alu_op = op;
        a      = x;
        b      = y;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst_n  = 1'b0;
        start  = 1'b0;
        alu_op = ALU_ADD;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", {15'd0, ready}, 16'd1);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_outs", {result_hi, result}, 16'd0);
        check("reset_flags", {13'd0, zero, carry_out, overflow}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        sb.push_back(mk("add_7f_01", 8'h80, 8'h00, 1'b0, 1'b1));
        issue(ALU_ADD, 8'h7F, 8'h01);

        sb.push_back(mk("sub_5_5", 8'h00, 8'h00, 1'b1, 1'b0));
        issue(ALU_SUB, 8'h05, 8'h05);
        check("b2b_ready", {15'd0, ready}, 16'd1);
        sb.push_back(mk("sub_3_5", 8'hFE, 8'h00, 1'b0, 1'b0));
        issue(ALU_SUB, 8'h03, 8'h05);
        check("b2b_ready2", {15'd0, ready}, 16'd1);

        sb.push_back(mk("slt_ff_01", 8'h01, 8'h00, 1'b0, 1'b0));
        issue(ALU_SLT, 8'hFF, 8'h01);
        sb.push_back(mk("slt_01_ff", 8'h00, 8'h00, 1'b0, 1'b0));
        issue(ALU_SLT, 8'h01, 8'hFF);
        sb.push_back(mk("slt_80_7f", 8'h01, 8'h00, 1'b0, 1'b0));
        issue(ALU_SLT, 8'h80, 8'h7F);

        sb.push_back(mk("xor", 8'hAA, 8'h00, 1'b0, 1'b0));
        issue(ALU_XOR, 8'hA5, 8'h0F);
        sb.push_back(mk("nor", 8'h50, 8'h00, 1'b0, 1'b0));
        issue(ALU_NOR, 8'hA5, 8'h0F);
        sb.push_back(mk("and", 8'h05, 8'h00, 1'b0, 1'b0));
        issue(ALU_AND, 8'hA5, 8'h0F);
        sb.push_back(mk("or", 8'hAF, 8'h00, 1'b0, 1'b0));
        issue(ALU_OR, 8'hA5, 8'h0F);
        @(negedge clk);

        // mult FF*FF = FE01; a stray add during busy cycle 4 must be dropped
        sb.push_back(mk("mult_ff_ff", 8'h01, 8'hFE, 1'b0, 1'b1));
        issue(ALU_MULT, 8'hFF, 8'hFF);
        for (int i = 1; i <= 9; i++) begin
            check($sformatf("mult_ready_c%0d", i), {15'd0, ready}, (i == 9) ? 16'd1 : 16'd0);
            check($sformatf("mult_done_c%0d", i), {15'd0, done}, (i == 9) ? 16'd1 : 16'd0);
            if (i == 4) begin
                start  = 1'b1;
                alu_op = ALU_ADD;
                a      = 8'h11;
                b      = 8'h22;
            end else begin
                start = 1'b0;
            end
            if (i < 9) @(negedge clk);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            sb.push_back(model(ALU_ADD, ra, rb));
            issue(ALU_ADD, ra, rb);
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            sb.push_back(model(ALU_SUB, ra, rb));
            issue(ALU_SUB, ra, rb);
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            sb.push_back(model(ALU_MULT, ra, rb));
            issue(ALU_MULT, ra, rb);
            repeat (9) @(negedge clk);
        end

        sb.push_back(mk("add_pre_rst", 8'h80, 8'h00, 1'b0, 1'b1));
        issue(ALU_ADD, 8'h7F, 8'h01);
        @(negedge clk);

        // mult aborted by reset at busy cycle 3: no expectation pushed, so any done is flagged
        issue(ALU_MULT, 8'h03, 8'h04);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {15'd0, ready}, 16'd1);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_outs", {result_hi, result}, 16'd0);
        check("abort_flags", {13'd0, zero, carry_out, overflow}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", {15'd0, done}, 16'd0);
        end

        sb.push_back(mk("add_post_rst", 8'h30, 8'h00, 1'b0, 1'b0));
        issue(ALU_ADD, 8'h10, 8'h20);
        repeat (3) @(negedge clk);

        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
